// File: rtl/b2b_pkg.sv
// Shared types and helpers for the back-to-back cluster event arbiter.
// The metadata flag is always the MSB of an event word, whatever the word width.
package b2b_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } b2b_state_e;

  // Widest event word the helpers accept; callers zero-extend into this.
  localparam int unsigned B2B_MAX_W = 256;
  localparam int unsigned B2B_IDX_W = $clog2(B2B_MAX_W);

  function automatic int unsigned meta_idx(input int unsigned data_width);
    return data_width - 1;
  endfunction

  function automatic logic is_meta(input logic [B2B_MAX_W-1:0] word,
                                   input int unsigned         data_width);
    return word[B2B_IDX_W'(meta_idx(data_width))];
  endfunction

endpackage

// File: rtl/b2b_rr_select.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping past the top index back to zero.
module b2b_rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    logic             found;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found        = 1'b1;
        grant_oh[jj] = 1'b1;
        grant_idx    = jj;
      end
    end
  end

endmodule

// File: rtl/b2b_cluster_arbiter.sv
// Merges framed events from several FWFT cluster FIFOs into one stream,
// granting whole events round-robin and dropping data words seen outside a frame.
module b2b_cluster_arbiter
  import b2b_pkg::*;
#(
  parameter int DATA_WIDTH     = 65,
  parameter int TOTAL_CLUSTERS = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              b2b_clk,
  input  logic                              b2b_srst,
  input  logic [DATA_WIDTH-1:0]             cluster_data  [TOTAL_CLUSTERS],
  input  logic                              cluster_empty [TOTAL_CLUSTERS],
  output logic                              cluster_req   [TOTAL_CLUSTERS],
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_wren,
  input  logic                              out_almost_full,
  output logic [$clog2(TOTAL_CLUSTERS)-1:0] grant_id,
  output logic                              busy,
  output logic                              frame_err,
  output logic [CNT_WIDTH-1:0]              event_count   [TOTAL_CLUSTERS]
);

  localparam int               IDX_W    = $clog2(TOTAL_CLUSTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_CLUSTERS - 1);

  b2b_state_e            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gid_p1;
  logic                  hdr_done;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  ferr_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1 [TOTAL_CLUSTERS];

  logic [TOTAL_CLUSTERS-1:0] eligible;
  logic [TOTAL_CLUSTERS-1:0] orphan;
  logic [TOTAL_CLUSTERS-1:0] sel_oh;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_any;
  logic [DATA_WIDTH-1:0]     pop_word;
  logic                      xfer_pop;
  logic                      pop_meta;
  logic                      footer_pop;

  // Stage p0: classify every FIFO head as frame start or stray data.
  always_comb begin
    eligible = '0;
    orphan   = '0;
    for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
      if (!cluster_empty[i]) begin
        if (is_meta(B2B_MAX_W'(cluster_data[i]), DATA_WIDTH)) eligible[i] = 1'b1;
        else                                                  orphan[i]   = 1'b1;
      end
    end
  end

  b2b_rr_select #(
    .N     (TOTAL_CLUSTERS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req       (eligible),
    .rr_ptr    (rr_ptr),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx)
  );

  assign sel_any    = |sel_oh;
  assign pop_word   = cluster_data[gid_p1];
  assign xfer_pop   = (state == XFER) && !cluster_empty[gid_p1] &&
                      !out_almost_full && !b2b_srst;
  assign pop_meta   = is_meta(B2B_MAX_W'(pop_word), DATA_WIDTH);
  // The header is the first pop of a grant; the next flagged pop closes it.
  assign footer_pop = xfer_pop && hdr_done && pop_meta;

  always_comb begin
    for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
      cluster_req[i] = 1'b0;
      if (!b2b_srst) begin
        if (state == ARB) cluster_req[i] = orphan[i];
        else              cluster_req[i] = xfer_pop && (gid_p1 == IDX_W'(i));
      end
    end
  end

  // Stage p1: registered stream word, error pulse and arbitration state.
  always_ff @(posedge b2b_clk) begin
    if (b2b_srst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      gid_p1   <= '0;
      hdr_done <= 1'b0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      ferr_p1  <= 1'b0;
      for (int i = 0; i < TOTAL_CLUSTERS; i++) cnt_p1[i] <= '0;
    end else begin
      vld_p1  <= xfer_pop;
      if (xfer_pop) data_p1 <= pop_word;
      ferr_p1 <= (state == ARB) && (|orphan);
      unique case (state)
        ARB: begin
          if (sel_any) begin
            state    <= XFER;
            gid_p1   <= sel_idx;
            rr_ptr   <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
            hdr_done <= 1'b0;
          end
        end
        XFER: begin
          if (xfer_pop) hdr_done <= 1'b1;
          if (footer_pop) begin
            state          <= ARB;
            hdr_done       <= 1'b0;
            cnt_p1[gid_p1] <= cnt_p1[gid_p1] + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign out_data    = data_p1;
  assign out_wren    = vld_p1;
  assign grant_id    = gid_p1;
  assign busy        = (state == XFER);
  assign frame_err   = ferr_p1;
  assign event_count = cnt_p1;

endmodule

// File: doc/b2b_cluster_arbiter.md
B2B_CLUSTER_ARBITER -- requirements
Module: b2b_cluster_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 65, giving the event word width; bit DATA_WIDTH-1 is the metadata flag.
REQ-002 The block SHALL have parameter TOTAL_CLUSTERS, default 4, giving the number of cluster input FIFOs (2..16).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of each per-cluster event counter.
REQ-004 The block SHALL have port b2b_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port b2b_srst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port cluster_data[TOTAL_CLUSTERS], input, DATA_WIDTH each: head word of each first-word-fall-through FIFO, valid while its empty flag is low.
REQ-007 The block SHALL have port cluster_empty[TOTAL_CLUSTERS], input, 1 bit each: FIFO empty.
REQ-008 The block SHALL have port cluster_req[TOTAL_CLUSTERS], output, 1 bit each: pop strobe, combinational.
REQ-009 The block SHALL have port out_data, output, DATA_WIDTH: the merged event stream word, registered.
REQ-010 The block SHALL have port out_wren, output, 1 bit: out_data valid, registered.
REQ-011 The block SHALL have port out_almost_full, input, 1 bit: downstream backpressure.
REQ-012 The block SHALL have port grant_id, output, $clog2(TOTAL_CLUSTERS) bits: the currently or last granted cluster.
REQ-013 The block SHALL have port busy, output, 1 bit: high in XFER.
REQ-014 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a discarded word.
REQ-015 The block SHALL have port event_count[TOTAL_CLUSTERS], output, CNT_WIDTH each: completed events per cluster.

Function
REQ-016 An event SHALL be a header word (metadata flag=1), zero or more data words (flag=0), then a footer word (flag=1); the first flagged word after the header is the footer.
REQ-017 The FSM SHALL have exactly two states, ARB and XFER, and SHALL enter ARB on reset.
REQ-018 In ARB, cluster i SHALL be eligible when cluster_empty[i]=0 and cluster_data[i] has flag=1.
REQ-019 In ARB, the eligible cluster SHALL be chosen round-robin, searching upward from rr_ptr and wrapping; the FSM SHALL then go to XFER with grant_id=i and rr_ptr=(i+1) mod TOTAL_CLUSTERS.
REQ-020 In ARB, the granting cycle SHALL pop nothing; the header SHALL be popped in XFER.
REQ-021 In ARB, every non-empty cluster whose head has flag=0 (orphan data) SHALL be popped and discarded; frame_err SHALL pulse for one cycle; such clusters are not eligible that cycle.
REQ-022 In XFER, cluster_req[grant_id] SHALL be driven as (cluster_empty[grant_id]=0 AND out_almost_full=0); all other cluster_req SHALL be 0.
REQ-023 Each pop SHALL produce out_data=popped word and out_wren=1 on the following cycle (latency 1); no other cycle asserts out_wren.
REQ-024 out_data SHALL hold its previous value when out_wren=0.
REQ-025 On popping the footer, the FSM SHALL return to ARB and event_count[grant_id] SHALL increment, wrapping modulo 2^CNT_WIDTH.
REQ-026 An empty FIFO or out_almost_full during XFER SHALL stall without releasing the grant; there is no timeout.
REQ-027 Back-to-back events SHALL have exactly one idle ARB cycle between a footer pop and the next header pop.
REQ-028 With no cluster eligible, the FSM SHALL remain in ARB with rr_ptr unchanged.

Reset
REQ-029 While b2b_srst=1: state=ARB; rr_ptr=0; grant_id=0; out_wren=0; out_data=0; busy=0; frame_err=0; all event_count=0; all cluster_req=0.
REQ-030 Reset asserted mid-event SHALL abandon the event without emitting a footer; remaining words are then treated per REQ-021.

Structure
REQ-031 A shared package b2b_pkg SHALL hold the FSM state enum, the metadata-flag bit index, and a helper function for the metadata-flag test.
REQ-032 The round-robin search SHALL be a sub-module b2b_rr_select (request vector and rr_ptr in; one-hot grant and index out; combinational).

Verification
REQ-033 Cluster 2 holds H, D0, D1, F and the others are empty: out_wren is high 4 consecutive cycles starting 2 cycles after data is present, out_data=H,D0,D1,F, event_count[2]=1.
REQ-034 All 4 clusters each hold one 3-word event and rr_ptr=0: events are emitted in order 0,1,2,3, separated by one idle cycle each, and each event_count=1.
REQ-035 out_almost_full=1 for 5 cycles mid-event: no pops and no out_wren during the stall, grant_id held, and the stream resumes intact.
REQ-036 Cluster 1 head is a data word (flag=0): it is popped, frame_err pulses for one cycle, and nothing is written out.
REQ-037 Reset is asserted after 2 of 5 words of an event: all outputs take their reset values, and after the orphan words are discarded the next full event is emitted correctly.
REQ-038 event_count[0] is driven to 2^16-1 and one more event completes: the counter wraps to 0.
